dm_access_controller: RTL

- Sequences MEM-stage load/store requests onto a single-ported 64-bit data memory with a valid/ready request channel and a variable-latency response channel.
- Drives the MEM-stage stall, byte-lane store data and byte enables, and returns the raw 64-bit dword to the load-extraction logic.
- Detects dword-crossing misaligned accesses before any memory traffic.
- Sits between the MEM pipeline register and the data memory.

---
 rtl/dm_access_controller_pkg.sv | 40 ++++
 rtl/dm_store_aligner.sv | 16 +
 rtl/dm_access_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/dm_access_controller_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access controller.
// Size codes, FSM state constants, byte-mask and misalignment helpers.
package dm_access_controller_pkg;

   typedef enum logic [1:0] {
      UNIT_B  = 2'd0,
      UNIT_HW = 2'd1,
      UNIT_W  = 2'd2,
      UNIT_DW = 2'd3
   } unit_e;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic logic [7:0] size_mask(input logic [1:0] unit);
      logic [7:0] mask;
      case (unit)
         UNIT_B:  mask = 8'h01;
         UNIT_HW: mask = 8'h03;
         UNIT_W:  mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // True when the access would spill past the end of its dword.
   function automatic logic is_misaligned(input logic [1:0] unit, input logic [2:0] off);
      logic mis;
      case (unit)
         UNIT_B:  mis = 1'b0;
         UNIT_HW: mis = (off == 3'd7);
         UNIT_W:  mis = (off >= 3'd5);
         default: mis = (off != 3'd0);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dm_store_aligner.sv
// Places an LSB-justified store value and its byte mask onto the dword lanes
// selected by the low address bits.
module dm_store_aligner
   import dm_access_controller_pkg::*;
(
   input  logic [1:0]  unit,
   input  logic [2:0]  off,
   input  logic [63:0] wdata,
   output logic [7:0]  be,
   output logic [63:0] wdata_sh
);

   assign be       = size_mask(unit) << off;
   assign wdata_sh = wdata << {off, 3'b000};

endmodule

// File: rtl/dm_access_controller.sv
// Sequences one MEM-stage load/store at a time onto a single-ported 64-bit data
// memory, holding the pipeline until the response (or a timeout) arrives.
module dm_access_controller
   import dm_access_controller_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_unit,
   input  logic [63:0]       req_wdata,
   output logic              mem_stall,
   output logic              rsp_valid,
   output logic [63:0]       rsp_rdata,
   output logic              misaligned_err,
   output logic              timeout_err,
   output logic              dm_req_valid,
   input  logic              dm_req_ready,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [7:0]        dm_be,
   output logic [63:0]       dm_wdata,
   input  logic              dm_rsp_valid,
   input  logic [63:0]       dm_rsp_rdata,
   output logic [1:0]        dbg_state
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   logic [1:0]  state;
   logic [7:0]  counter;
   logic        req_go;
   logic        req_mis;
   logic [7:0]  al_be;
   logic [63:0] al_wdata;

   dm_store_aligner u_aligner (
      .unit     (req_unit),
      .off      (req_addr[2:0]),
      .wdata    (req_wdata),
      .be       (al_be),
      .wdata_sh (al_wdata)
   );

   assign req_go  = req_valid && (req_rd || req_wr);
   assign req_mis = is_misaligned(req_unit, req_addr[2:0]);

   // Memory channel: a request transfers on the cycle dm_req_valid && dm_req_ready;
   // valid and every request field stay constant until that cycle. The response
   // side has no back-pressure: dm_rsp_valid is only honoured while in WAIT.
   assign dm_req_valid = (state == ST_ISSUE);
   assign rsp_valid    = (state == ST_DONE) && !dm_we;
   assign mem_stall    = ((state == ST_IDLE) && req_go && !req_mis)
                         || (state == ST_ISSUE) || (state == ST_WAIT);
   assign dbg_state    = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         counter        <= 8'd0;
         rsp_rdata      <= 64'd0;
         misaligned_err <= 1'b0;
         timeout_err    <= 1'b0;
         dm_we          <= 1'b0;
         dm_addr        <= '0;
         dm_be          <= 8'd0;
         dm_wdata       <= 64'd0;
      end else begin
         misaligned_err <= 1'b0;
         timeout_err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_go) begin
                  if (req_mis) begin
                     misaligned_err <= 1'b1;
                  end else begin
                     dm_we    <= req_wr;
                     dm_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                     dm_be    <= al_be;
                     dm_wdata <= al_wdata;
                     state    <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (dm_req_ready) begin
                  counter <= 8'd0;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A response arriving on the timeout cycle still wins.
               if (dm_rsp_valid) begin
                  if (!dm_we) begin
                     rsp_rdata <= dm_rsp_rdata;
                  end
                  state <= ST_DONE;
               end else if (counter == TIMEOUT_CNT) begin
                  timeout_err <= 1'b1;
                  rsp_rdata   <= 64'd0;
                  state       <= ST_DONE;
               end else begin
                  counter <= counter + 8'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
